// File: rtl/fc_pkg.sv
// Shared constants and types for the flow-control response generator:
// CHDR type codes, header field positions, FSM encodings and the FC header builder.
package fc_pkg;

   localparam logic [1:0]  CHDR_TYPE_DATA = 2'b00;
   localparam logic [1:0]  CHDR_TYPE_FC   = 2'b01;

   localparam int          HDR_TYPE_MSB   = 63;
   localparam int          HDR_TYPE_LSB   = 62;
   localparam int          HDR_SID_MSB    = 31;
   localparam int          HDR_SID_LSB    = 0;

   localparam logic [15:0] FC_PKT_LEN     = 16'd16;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_HEAD = 2'd1,
      ST_BODY = 2'd2
   } fc_state_e;

   // SID halves are swapped so the ack is addressed back to the original source.
   function automatic logic [63:0] fc_header(input logic [11:0] seqnum, input logic [31:0] sid);
      return {CHDR_TYPE_FC, 1'b0, 1'b0, seqnum, FC_PKT_LEN, sid[15:0], sid[31:16]};
   endfunction

endpackage

// File: rtl/fc_response_gen_tracker.sv
// CHDR packet tracker: first-line flag, data-packet flag, SID capture and an
// end-of-data-packet strobe for the flow-control responder.
module chdr_pkt_tracker
   import fc_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        clr_i,
   input  logic        beat_i,
   input  logic [63:0] tdata_i,
   input  logic        tlast_i,
   output logic [31:0] sid_o,
   output logic        data_eop_o
);

   logic        first_line_q, first_line_d;
   logic        is_data_q, is_data_d;
   logic [31:0] sid_q, sid_d;
   logic        hdr_is_data;
   logic        cur_is_data;
   logic [29:0] unused_hdr;

   assign unused_hdr  = tdata_i[61:32];
   assign hdr_is_data = (tdata_i[HDR_TYPE_MSB:HDR_TYPE_LSB] == CHDR_TYPE_DATA);
   // One-beat packets end on their header, so the type must be taken live there.
   assign cur_is_data = first_line_q ? hdr_is_data : is_data_q;
   assign data_eop_o  = beat_i & tlast_i & cur_is_data;
   assign sid_o       = sid_q;

   always_comb begin
      first_line_d = first_line_q;
      is_data_d    = is_data_q;
      sid_d        = sid_q;
      if (beat_i) begin
         first_line_d = tlast_i;
         if (first_line_q) begin
            is_data_d = hdr_is_data;
            sid_d     = tdata_i[HDR_SID_MSB:HDR_SID_LSB];
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         first_line_q <= 1'b1;
         is_data_q    <= 1'b0;
         sid_q        <= '0;
      end else if (clr_i) begin
         first_line_q <= 1'b1;
         is_data_q    <= 1'b0;
         sid_q        <= '0;
      end else begin
         first_line_q <= first_line_d;
         is_data_q    <= is_data_d;
         sid_q        <= sid_d;
      end
   end

endmodule

// File: rtl/setting_reg.sv
// Single settings-bus register: loads data_i when strobe_i hits MY_ADDR.
// Cleared to AT_RESET by async rst or synchronous clr_i.
module setting_reg #(
   parameter logic [7:0] MY_ADDR  = 8'd0,
   parameter int         WIDTH    = 32,
   parameter logic [WIDTH-1:0] AT_RESET = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr_i,
   input  logic             strobe_i,
   input  logic [7:0]       addr_i,
   input  logic [31:0]      data_i,
   output logic [WIDTH-1:0] out_o
);

   logic [WIDTH-1:0] out_q;
   logic [31:0]      unused_data;

   assign unused_data = data_i;
   assign out_o       = out_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_q <= AT_RESET;
      end else if (clr_i) begin
         out_q <= AT_RESET;
      end else if (strobe_i && (addr_i == MY_ADDR)) begin
         out_q <= data_i[WIDTH-1:0];
      end
   end

endmodule

// File: rtl/fc_response_gen.sv
// Sink-side flow-control responder: passes CHDR through and emits a 2-line FC ack
// after a threshold of consumed data packets. FC_RESP_CYCLE_TIMER_EN adds an idle-timer trigger.
//
//  state | meaning
//  IDLE  | evaluate pending; latch snapshot of consumed on exit
//  HEAD  | present FC header line
//  BODY  | present FC body (snap - 1); commit last_reported on handshake
module fc_response_gen
   import fc_pkg::*;
#(
   parameter logic [7:0] SR_FC_RESP_PKTS   = 8'd0,
   parameter logic [7:0] SR_FC_RESP_CYCLES = 8'd1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        clear,
   input  logic        set_stb,
   input  logic [7:0]  set_addr,
   input  logic [31:0] set_data,
   input  logic [63:0] in_tdata,
   input  logic        in_tlast,
   input  logic        in_tvalid,
   output logic        in_tready,
   output logic [63:0] out_tdata,
   output logic        out_tlast,
   output logic        out_tvalid,
   input  logic        out_tready,
   output logic [63:0] fc_tdata,
   output logic        fc_tlast,
   output logic        fc_tvalid,
   input  logic        fc_tready,
   output logic [31:0] debug
);

   fc_state_e   state_q, state_d;
   logic [31:0] consumed_q, consumed_d;
   logic [31:0] last_reported_q, last_reported_d;
   logic [31:0] snap_q, snap_d;
   logic [31:0] fc_sid_q, fc_sid_d;
   logic [11:0] fc_seqnum_q, fc_seqnum_d;
   logic [15:0] pkts_per_ack;
   logic [31:0] sid;
   logic [31:0] outstanding;
   logic        data_eop;
   logic        count_hit;
   logic        timer_hit;
   logic        pending;
   logic        fc_done;

   assign out_tdata  = in_tdata;
   assign out_tlast  = in_tlast;
   assign out_tvalid = in_tvalid;
   assign in_tready  = out_tready;

   chdr_pkt_tracker u_tracker (
      .clk        (clk),
      .rst        (reset),
      .clr_i      (clear),
      .beat_i     (in_tvalid & out_tready),
      .tdata_i    (in_tdata),
      .tlast_i    (in_tlast),
      .sid_o      (sid),
      .data_eop_o (data_eop)
   );

   setting_reg #(.MY_ADDR(SR_FC_RESP_PKTS), .WIDTH(16)) u_pkts_reg (
      .clk      (clk),
      .rst      (reset),
      .clr_i    (clear),
      .strobe_i (set_stb),
      .addr_i   (set_addr),
      .data_i   (set_data),
      .out_o    (pkts_per_ack)
   );

   // Modular subtraction keeps the comparison valid across consumed wrapping.
   assign outstanding = consumed_q - last_reported_q;
   assign count_hit   = (pkts_per_ack != 16'd0) && (outstanding >= {16'd0, pkts_per_ack});
   assign pending     = count_hit | timer_hit;
   assign fc_done     = (state_q == ST_BODY) && fc_tready;

`ifdef FC_RESP_CYCLE_TIMER_EN
   logic [31:0] cycles_per_ack;
   logic [31:0] timer_q, timer_d;

   setting_reg #(.MY_ADDR(SR_FC_RESP_CYCLES), .WIDTH(32)) u_cycles_reg (
      .clk      (clk),
      .rst      (reset),
      .clr_i    (clear),
      .strobe_i (set_stb),
      .addr_i   (set_addr),
      .data_i   (set_data),
      .out_o    (cycles_per_ack)
   );

   assign timer_hit = (cycles_per_ack != 32'd0) && (timer_q >= cycles_per_ack);

   always_comb begin
      timer_d = timer_q;
      if (fc_done) begin
         timer_d = '0;
      end else if ((consumed_q != last_reported_q) && !timer_hit) begin
         timer_d = timer_q + 32'd1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         timer_q <= '0;
      end else if (clear) begin
         timer_q <= '0;
      end else begin
         timer_q <= timer_d;
      end
   end
`else
   localparam logic [7:0] cycles_addr_unused = SR_FC_RESP_CYCLES;
   assign timer_hit = 1'b0;
`endif

   always_comb begin
      state_d         = state_q;
      consumed_d      = consumed_q + {31'd0, data_eop};
      last_reported_d = last_reported_q;
      snap_d          = snap_q;
      fc_sid_d        = fc_sid_q;
      fc_seqnum_d     = fc_seqnum_q;
      fc_tvalid       = 1'b0;
      fc_tlast        = 1'b0;
      fc_tdata        = '0;
      case (state_q)
         ST_IDLE: begin
            if (pending) begin
               state_d  = ST_HEAD;
               snap_d   = consumed_q;
               fc_sid_d = sid;
            end
         end
         ST_HEAD: begin
            fc_tvalid = 1'b1;
            fc_tdata  = fc_header(fc_seqnum_q, fc_sid_q);
            if (fc_tready) begin
               state_d = ST_BODY;
            end
         end
         ST_BODY: begin
            fc_tvalid = 1'b1;
            fc_tlast  = 1'b1;
            fc_tdata  = {32'd0, snap_q - 32'd1};
            if (fc_tready) begin
               state_d         = ST_IDLE;
               last_reported_d = snap_q;
               fc_seqnum_d     = fc_seqnum_q + 12'd1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q         <= ST_IDLE;
         consumed_q      <= '0;
         last_reported_q <= '0;
         snap_q          <= '0;
         fc_sid_q        <= '0;
         fc_seqnum_q     <= '0;
      end else if (clear) begin
         state_q         <= ST_IDLE;
         consumed_q      <= '0;
         last_reported_q <= '0;
         snap_q          <= '0;
         fc_sid_q        <= '0;
         fc_seqnum_q     <= '0;
      end else begin
         state_q         <= state_d;
         consumed_q      <= consumed_d;
         last_reported_q <= last_reported_d;
         snap_q          <= snap_d;
         fc_sid_q        <= fc_sid_d;
         fc_seqnum_q     <= fc_seqnum_d;
      end
   end

   assign debug = {state_q, pending, 1'b0, fc_seqnum_q[3:0], consumed_q[11:0], last_reported_q[11:0]};

endmodule
